warmboot_controller: RTL and testbench

Fabric-external controller at the far end of the warmboot tile's BOOT/SLOT outputs. It synchronizes the fabric-driven BOOT strobe and 4-bit SLOT select, then requests a bitstream reload from the configuration loader at a slot-derived flash address. It holds the fabric in reset while reconfiguration runs and for a programmable interval afterwards. Its fabric_reset_o drives the tile's RESET input, closing the loop back into the fabric.

---
 rtl/warmboot_pkg.sv | 30 +++
 rtl/wb_sync.sv | 25 ++
 rtl/warmboot_controller.sv | 142 ++++++++++++++
 tb/tb_warmboot_controller.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/warmboot_pkg.sv
// Shared types, default widths and helpers for the warmboot controller.
package warmboot_pkg;

  typedef enum logic [2:0] {
    DISARMED,
    IDLE,
    REQ,
    LOAD,
    HOLD
  } wb_state_t;

  localparam int unsigned WB_SYNC_STAGES = 2;
  localparam int unsigned WB_SLOT_W      = 4;
  localparam int unsigned WB_ADDR_W      = 24;
  localparam int unsigned WB_ADDR_SHIFT  = 20;
  localparam int unsigned WB_RESET_HOLD  = 16;
  localparam int unsigned WB_TIMEOUT     = 1 << 20;

  // Larger of two sizing constants.
  function automatic int unsigned wb_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Flash base address for a slot; callers truncate to their address width.
  function automatic logic [63:0] slot_to_addr(input logic [31:0] slot,
                                               input int unsigned shift);
    return 64'(slot) << shift;
  endfunction

endpackage

// File: rtl/wb_sync.sv
// N-stage, W-bit synchronizer chain with synchronous clear.
module wb_sync #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [N-1:0][W-1:0] chain;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[N-2:0], d};
    end
  end

  assign q = chain[N-1];

endmodule

// File: rtl/warmboot_controller.sv
// Synchronizes BOOT/SLOT from the fabric, requests a reload from the
// configuration loader and holds the fabric in reset around the reload.
module warmboot_controller
  import warmboot_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = WB_SYNC_STAGES,
  parameter int unsigned SLOT_W      = WB_SLOT_W,
  parameter int unsigned ADDR_W      = WB_ADDR_W,
  parameter int unsigned ADDR_SHIFT  = WB_ADDR_SHIFT,
  parameter int unsigned RESET_HOLD  = WB_RESET_HOLD,
  parameter int unsigned TIMEOUT     = WB_TIMEOUT
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              boot_i,
  input  logic [SLOT_W-1:0] slot_i,
  output logic              boot_req_o,
  output logic [ADDR_W-1:0] boot_addr_o,
  input  logic              boot_ack_i,
  input  logic              boot_done_i,
  output logic              fabric_reset_o,
  output logic              busy_o,
  output logic              error_o
);

  // One counter serves the DISARMED settle wait, LOAD timeout and HOLD interval.
  localparam int unsigned CNT_MAX = wb_max(wb_max(TIMEOUT, RESET_HOLD), SYNC_STAGES + 1);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_FIRST = CNT_W'(RESET_HOLD - 1);
  localparam logic [CNT_W-1:0] SETTLED    = CNT_W'(SYNC_STAGES);

  wb_state_t         state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [SLOT_W-1:0] slot_q, slot_nxt;
  logic              error_q, error_nxt;
  logic              boot_s, boot_prev;
  logic [SLOT_W-1:0] slot_s;
  logic              trigger;

  wb_sync #(.N(SYNC_STAGES), .W(1)) u_boot_sync (
    .clk   (CLK),
    .reset (reset),
    .d     (boot_i),
    .q     (boot_s)
  );

  wb_sync #(.N(SYNC_STAGES), .W(SLOT_W)) u_slot_sync (
    .clk   (CLK),
    .reset (reset),
    .d     (slot_i),
    .q     (slot_s)
  );

  assign trigger = boot_s & ~boot_prev;

  // State, counter, latched slot, sticky error and BOOT edge history.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= DISARMED;
      cnt       <= '0;
      slot_q    <= '0;
      error_q   <= 1'b0;
      boot_prev <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      slot_q    <= slot_nxt;
      error_q   <= error_nxt;
      boot_prev <= boot_s;
    end
  end

  // Next-state, counter and error decisions.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    slot_nxt  = slot_q;
    error_nxt = error_q;
    unique case (state)
      // After reset the synchronizer holds its cleared value for SYNC_STAGES
      // cycles; wait that out so a BOOT held high across reset is seen as high
      // and cannot re-trigger. Leaving HOLD preloads SETTLED, skipping the wait.
      DISARMED: begin
        if (cnt >= SETTLED) begin
          if (!boot_s) state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      IDLE: begin
        if (trigger) begin
          slot_nxt  = slot_s;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (boot_ack_i) begin
          if (boot_done_i) begin
            state_nxt = HOLD;
            cnt_nxt   = HOLD_FIRST;
          end else begin
            state_nxt = LOAD;
            cnt_nxt   = '0;
          end
        end
      end
      LOAD: begin
        if (boot_done_i) begin
          state_nxt = HOLD;
          cnt_nxt   = HOLD_FIRST;
        end else if (cnt == LOAD_LAST) begin
          error_nxt = 1'b1;
          state_nxt = HOLD;
          cnt_nxt   = HOLD_FIRST;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_nxt = DISARMED;
          cnt_nxt   = SETTLED;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = DISARMED;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign boot_req_o     = (state == REQ);
  assign fabric_reset_o = (state == LOAD) || (state == HOLD);
  assign busy_o         = (state == REQ) || (state == LOAD) || (state == HOLD);
  assign error_o        = error_q;
  assign boot_addr_o    = ADDR_W'(slot_to_addr(32'(slot_q), ADDR_SHIFT));

endmodule

// File: tb/tb_warmboot_controller.sv
// Randomized + directed bench for warmboot_controller against a behavioural model.
module tb_warmboot_controller;

  localparam int unsigned S    = 2;
  localparam int unsigned HOLD = 4;
  localparam int unsigned TO_A = 32;
  localparam int unsigned TO_B = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, boot, ack, done;
  logic [3:0] slot;

  logic        req_a, frst_a, busy_a, err_a;
  logic [23:0] addr_a;
  logic        req_b, frst_b, busy_b, err_b;
  logic [23:0] addr_b;

  warmboot_controller #(
    .SYNC_STAGES(S), .SLOT_W(4), .ADDR_W(24), .ADDR_SHIFT(20),
    .RESET_HOLD(HOLD), .TIMEOUT(TO_A)
  ) dut_a (
    .CLK(clk), .reset(rst), .boot_i(boot), .slot_i(slot),
    .boot_req_o(req_a), .boot_addr_o(addr_a), .boot_ack_i(ack),
    .boot_done_i(done), .fabric_reset_o(frst_a), .busy_o(busy_a), .error_o(err_a)
  );

  warmboot_controller #(
    .SYNC_STAGES(S), .SLOT_W(4), .ADDR_W(24), .ADDR_SHIFT(20),
    .RESET_HOLD(HOLD), .TIMEOUT(TO_B)
  ) dut_b (
    .CLK(clk), .reset(rst), .boot_i(boot), .slot_i(slot),
    .boot_req_o(req_b), .boot_addr_o(addr_b), .boot_ack_i(ack),
    .boot_done_i(done), .fabric_reset_o(frst_b), .busy_o(busy_b), .error_o(err_b)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: delay lines for the synchronizers, and per instance
  // a request flag, LOAD cycle count, remaining hold cycles and an arm flag.
  logic        bpipe [S];
  logic [3:0]  spipe [S];
  logic        bprev = 1'b0;
  bit          m_req   [2] = '{0, 0};
  bit          m_load  [2] = '{0, 0};
  bit          m_armed [2] = '{0, 0};
  bit          m_err   [2] = '{0, 0};
  int unsigned m_hold  [2] = '{0, 0};
  int unsigned m_lcnt  [2] = '{0, 0};
  int unsigned m_settle[2] = '{0, 0};
  logic [3:0]  m_slot  [2] = '{4'h0, 4'h0};
  int unsigned m_to    [2] = '{TO_A, TO_B};

  task automatic model_step();
    logic bs, trig;
    logic [3:0] ss;
    bs   = bpipe[S-1];
    ss   = spipe[S-1];
    trig = bs && !bprev;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_req[i] = 0; m_load[i] = 0; m_armed[i] = 0; m_err[i] = 0;
        m_hold[i] = 0; m_lcnt[i] = 0; m_settle[i] = 0; m_slot[i] = 4'h0;
      end else if (m_req[i]) begin
        if (ack) begin
          m_req[i] = 0;
          if (done) m_hold[i] = HOLD;
          else begin m_load[i] = 1; m_lcnt[i] = 0; end
        end
      end else if (m_load[i]) begin
        m_lcnt[i]++;
        if (done) begin
          m_load[i] = 0; m_hold[i] = HOLD;
        end else if (m_lcnt[i] == m_to[i]) begin
          m_err[i] = 1; m_load[i] = 0; m_hold[i] = HOLD;
        end
      end else if (m_hold[i] > 0) begin
        m_hold[i]--;
        if (m_hold[i] == 0) begin m_armed[i] = 0; m_settle[i] = S; end
      end else if (!m_armed[i]) begin
        if (m_settle[i] >= S && !bs) m_armed[i] = 1;
        else if (m_settle[i] < S) m_settle[i]++;
      end else if (trig) begin
        m_slot[i] = ss;
        m_req[i]  = 1;
      end
    end
    if (rst) begin
      bprev = 1'b0;
      for (int k = 0; k < S; k++) begin bpipe[k] = 1'b0; spipe[k] = 4'h0; end
    end else begin
      bprev = bs;
      for (int k = S - 1; k > 0; k--) begin bpipe[k] = bpipe[k-1]; spipe[k] = spipe[k-1]; end
      bpipe[0] = boot;
      spipe[0] = slot;
    end
  endtask

  task automatic check_dut(input string name, input int i, input logic req,
                           input logic [23:0] addr, input logic frst,
                           input logic busy, input logic err);
    logic exp_frst;
    exp_frst = m_load[i] || (m_hold[i] > 0);
    check({name, ".req"},  32'(req),  32'(m_req[i]));
    check({name, ".addr"}, 32'(addr), 32'({m_slot[i], 20'h00000}));
    check({name, ".frst"}, 32'(frst), 32'(exp_frst));
    check({name, ".busy"}, 32'(busy), 32'(m_req[i] || exp_frst));
    check({name, ".err"},  32'(err),  32'(m_err[i]));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_dut("a", 0, req_a, addr_a, frst_a, busy_a, err_a);
    check_dut("b", 1, req_b, addr_b, frst_b, busy_b, err_b);
  endtask

  task automatic wait_req_a(input string tag);
    int n = 0;
    while (!req_a && n < 20) begin cycle(); n++; end
    check(tag, 32'(req_a), 32'd1);
  endtask

  task automatic pulse_boot(input logic [3:0] s);
    slot = s; boot = 1'b1; cycle(); boot = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < S; k++) begin bpipe[k] = 1'b0; spipe[k] = 4'h0; end
    rst = 1'b1; boot = 1'b1; slot = 4'h0; ack = 1'b0; done = 1'b0;
    repeat (3) cycle();
    check("reset.req", 32'(req_a), 32'd0);
    check("reset.frst", 32'(frst_a), 32'd0);

    // BOOT held high across reset must not trigger.
    rst = 1'b0;
    repeat (6) cycle();
    check("disarmed.req", 32'(req_a), 32'd0);
    boot = 1'b0;
    repeat (4) cycle();
    boot = 1'b1;
    wait_req_a("rearm.req");
    boot = 1'b0;
    ack = 1'b1; cycle(); ack = 1'b0;
    repeat (3) cycle();
    done = 1'b1; cycle(); done = 1'b0;
    repeat (8) cycle();

    // Basic reload, slot stability, ignored BOOT during LOAD.
    pulse_boot(4'h3);
    wait_req_a("basic.req");
    check("basic.addr", 32'(addr_a), 32'h300000);
    repeat (3) cycle();
    ack = 1'b1; cycle(); ack = 1'b0;
    check("basic.frst", 32'(frst_a), 32'd1);
    pulse_boot(4'h9);
    repeat (13) cycle();
    check("stable.addr", 32'(addr_a), 32'h300000);
    check("stable.req", 32'(req_a), 32'd0);
    done = 1'b1; cycle(); done = 1'b0;
    repeat (4) cycle();
    check("basic.busy", 32'(busy_a), 32'd0);
    check("timeout_b.err", 32'(err_b), 32'd1);
    repeat (6) cycle();

    // Ack and done together in REQ.
    pulse_boot(4'h5);
    wait_req_a("coinc.req");
    ack = 1'b1; done = 1'b1; cycle(); ack = 1'b0; done = 1'b0;
    check("coinc.frst", 32'(frst_a), 32'd1);
    check("coinc.err", 32'(err_a), 32'd0);
    repeat (8) cycle();

    // Timeout on the long-TIMEOUT instance.
    pulse_boot(4'hA);
    wait_req_a("to_a.req");
    ack = 1'b1; cycle(); ack = 1'b0;
    repeat (40) cycle();
    check("to_a.err", 32'(err_a), 32'd1);
    repeat (4) cycle();

    // Reset during HOLD.
    pulse_boot(4'h6);
    wait_req_a("midrst.req");
    ack = 1'b1; done = 1'b1; cycle(); ack = 1'b0; done = 1'b0;
    cycle();
    rst = 1'b1; cycle(); rst = 1'b0;
    check("midrst.frst", 32'(frst_a), 32'd0);
    check("midrst.err", 32'(err_a), 32'd0);
    repeat (6) cycle();

    // Random traffic, including stray ack/done and occasional reset.
    for (int c = 0; c < 3000; c++) begin
      rst  = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 5) == 0) boot = ~boot;
      if ($urandom_range(0, 7) == 0) slot = 4'($urandom_range(0, 15));
      ack  = ($urandom_range(0, 3) == 0);
      done = ($urandom_range(0, 11) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
